// File: rtl/data_io_pkg.sv
// Shared constants and state encoding for the UIO file-download port.
package data_io_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
    localparam logic [7:0] JMP_OPCODE      = 8'hC3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        ERASE
    } state_t;

endpackage

// File: rtl/data_io_wfifo.sv
// Synchronous write FIFO; head entry is read straight from storage.
module data_io_wfifo
    import data_io_pkg::*;
#(
    parameter int W = 33,
    parameter int D = 8,
    localparam int PW = $clog2(D)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(D));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/data_io_fifo.sv
// UIO file-transfer receiver: SPI oversampling, load/patch/erase control,
// RAM write requests through a small FIFO with a ready handshake.
module data_io_fifo
    import data_io_pkg::*;
#(
    parameter int            AW         = 25,
    parameter int            FIFO_DEPTH = 8,
    parameter logic [AW-1:0] BASE_IDX0  = 'h10000,
    parameter logic [AW-1:0] BASE_IDXN  = 'h100000,
    parameter bit            PATCH_EN   = 1'b1,
    parameter bit            ERASE_EN   = 1'b1,
    parameter logic [AW-1:0] ERASE_END  = 'h10000,
    parameter logic [7:0]    FILL       = 8'h00
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spi_sck,
    input  logic          spi_ss,
    input  logic          spi_sdi,
    output logic          downloading,
    output logic [4:0]    index,
    output logic          overflow,
    output logic          ram_wr,
    input  logic          ram_ready,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    sck_q, ss_q, sdi_q;
    logic          sck_d, rise;
    logic [2:0]    bcnt;
    logic [6:0]    sr;
    logic          have_cmd;
    logic [7:0]    cmd, rx;
    logic          rx_v;
    logic          start, stop, dat;
    state_t        state, nxt;
    logic [AW-1:0] ptr, ers_addr, ers_nxt;
    logic          ers_on, ers_hs, ers_last, erase_go;
    logic          lnz, pend2;
    logic [1:0]    hcnt;
    logic [7:0]    hi;
    logic          hdr, hdr0, hdr1;
    logic          push, pop, acc, two_free;
    logic [AW+7:0] wdin, head;
    logic          full, empty;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_q <= '0;
            ss_q  <= 2'b11;
            sdi_q <= '0;
            sck_d <= 1'b0;
        end else begin
            sck_q <= {sck_q[0], spi_sck};
            ss_q  <= {ss_q[0], spi_ss};
            sdi_q <= {sdi_q[0], spi_sdi};
            sck_d <= sck_q[1];
        end
    end

    assign rise = sck_q[1] && !sck_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt     <= '0;
            sr       <= '0;
            have_cmd <= 1'b0;
            cmd      <= '0;
            rx       <= '0;
            rx_v     <= 1'b0;
        end else begin
            rx_v <= 1'b0;
            if (ss_q[1]) begin
                bcnt     <= '0;
                have_cmd <= 1'b0;
            end else if (rise) begin
                sr   <= {sr[5:0], sdi_q[1]};
                bcnt <= bcnt + 3'd1;
                if (bcnt == 3'd7) begin
                    if (!have_cmd) begin
                        cmd      <= {sr, sdi_q[1]};
                        have_cmd <= 1'b1;
                    end else begin
                        rx   <= {sr, sdi_q[1]};
                        rx_v <= 1'b1;
                    end
                end
            end
        end
    end

    assign start = rx_v && (cmd == UIO_FILE_TX) && rx[0];
    assign stop  = rx_v && (cmd == UIO_FILE_TX) && !rx[0];
    assign dat   = rx_v && (cmd == UIO_FILE_TX_DAT) && (state == LOAD);

    assign hdr      = PATCH_EN && lnz && (hcnt != 2'd2);
    assign hdr0     = hdr && (hcnt == 2'd0);
    assign hdr1     = hdr && (hcnt == 2'd1);
    assign pop      = !ers_on && ram_ready;
    assign acc      = !full || (pop && !empty);
    assign two_free = cnt <= CW'(FIFO_DEPTH - 2);
    assign ers_hs   = ers_on && ram_ready;
    assign ers_nxt  = ers_addr + 1'b1;
    assign ers_last = (ers_nxt == ERASE_END);
    assign erase_go = ERASE_EN && lnz && (ptr < ERASE_END);

    always_comb begin
        push = 1'b0;
        wdin = '0;
        if (pend2) begin
            push = 1'b1;
            wdin = {AW'(2), hi};
        end else if (dat) begin
            unique case (1'b1)
                hdr0: begin
                    push = 1'b1;
                    wdin = {AW'(0), JMP_OPCODE};
                end
                hdr1: begin
                    push = two_free;
                    wdin = {AW'(1), rx};
                end
                !hdr: begin
                    push = 1'b1;
                    wdin = {ptr, rx};
                end
            endcase
        end
    end

    always_comb begin
        nxt = state;
        if (start) begin
            nxt = LOAD;
        end else begin
            unique case (state)
                LOAD:    if (stop) nxt = DRAIN;
                DRAIN:   if (empty && !pend2 && !ers_on)
                             nxt = erase_go ? ERASE : IDLE;
                ERASE:   if (ers_hs && ers_last) nxt = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index    <= '0;
            overflow <= 1'b0;
            ptr      <= '0;
            lnz      <= 1'b0;
            hcnt     <= '0;
            hi       <= '0;
            pend2    <= 1'b0;
            ers_on   <= 1'b0;
            ers_addr <= '0;
        end else begin
            pend2 <= 1'b0;
            if (rx_v && (cmd == UIO_FILE_INDEX)) index <= rx[4:0];
            if (start) begin
                lnz      <= (index != '0);
                ptr      <= (index == '0) ? BASE_IDX0 : BASE_IDXN;
                overflow <= 1'b0;
                hcnt     <= '0;
            end else if (dat) begin
                unique case (1'b1)
                    hdr0: begin
                        hi   <= rx;
                        hcnt <= 2'd1;
                        if (!acc) overflow <= 1'b1;
                    end
                    hdr1: begin
                        ptr   <= AW'({hi, rx});
                        hcnt  <= 2'd2;
                        pend2 <= two_free;
                        if (!two_free) overflow <= 1'b1;
                    end
                    !hdr: begin
                        ptr <= ptr + 1'b1;
                        if (!acc) overflow <= 1'b1;
                    end
                endcase
            end
            // An aborted erase keeps presenting its write until it is taken.
            if (state == DRAIN && nxt == ERASE) begin
                ers_on   <= 1'b1;
                ers_addr <= ptr;
            end else if (ers_hs) begin
                ers_addr <= ers_nxt;
                if (state != ERASE || start || ers_last) ers_on <= 1'b0;
            end
        end
    end

    data_io_wfifo #(
        .W (AW + 8),
        .D (FIFO_DEPTH)
    ) u_wfifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (wdin),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (cnt)
    );

    assign downloading = (state != IDLE);
    assign ram_wr      = ers_on || !empty;
    assign ram_addr    = ers_on ? ers_addr : (empty ? '0 : head[AW+7:8]);
    assign ram_data    = ers_on ? FILL : (empty ? 8'h00 : head[7:0]);

endmodule

// File: tb/tb_data_io_fifo.sv
// Directed bench for data_io_fifo: load, patch, erase, overflow, abort, reset.
module tb_data_io_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        downloading;
    logic [4:0]  index;
    logic        overflow;
    logic        ram_wr;
    logic        ram_ready = 1'b1;
    logic [24:0] ram_addr;
    logic [7:0]  ram_data;

    int checks = 0;
    int failures = 0;
    logic [32:0] wq[$];

    always #5 clk = ~clk;

    data_io_fifo #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sck     (spi_sck),
        .spi_ss      (spi_ss),
        .spi_sdi     (spi_sdi),
        .downloading (downloading),
        .index       (index),
        .overflow    (overflow),
        .ram_wr      (ram_wr),
        .ram_ready   (ram_ready),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data)
    );

    always @(negedge clk)
        if (reset_n && ram_wr && ram_ready) wq.push_back({ram_addr, ram_data});

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        spi_sdi = b;
        clks(3);
        spi_sck = 1'b1;
        clks(3);
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic ss_lo();
        spi_ss = 1'b0;
        clks(3);
    endtask

    task automatic ss_hi();
        clks(3);
        spi_ss = 1'b1;
        clks(6);
    endtask

    task automatic frame2(input logic [7:0] c, input logic [7:0] d);
        ss_lo();
        send_byte(c);
        send_byte(d);
        ss_hi();
    endtask

    task automatic wait_idle(input int n, input string tag);
        int k = 0;
        while (downloading && k < n) begin
            @(negedge clk);
            k++;
        end
        chk(tag, downloading, 0);
    endtask

    initial begin
        logic [7:0]  t1 [4];
        int          bad;
        int          n0;
        int          k;
        logic [24:0] last;

        t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;
        clks(3);
        chk("rst_dl", downloading, 0);
        chk("rst_idx", index, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_wr", ram_wr, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        reset_n = 1'b1;
        clks(3);

        // Plain ROM load at index 0.
        wq.delete();
        frame2(8'h55, 8'h00);
        frame2(8'h53, 8'h01);
        chk("t1_dl", downloading, 1);
        ss_lo();
        send_byte(8'h54);
        for (int i = 0; i < 4; i++) send_byte(t1[i]);
        ss_hi();
        frame2(8'h53, 8'h00);
        wait_idle(20, "t1_idle");
        chk("t1_n", wq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t1_wr", wq[i], {25'h10000 + 25'(i), t1[i]});

        // Index 1: header patch then erase to ERASE_END.
        wq.delete();
        frame2(8'h55, 8'h01);
        chk("t2_idx", index, 1);
        frame2(8'h53, 8'h01);
        ss_lo();
        send_byte(8'h54);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAA);
        send_byte(8'hBB);
        ss_hi();
        frame2(8'h53, 8'h00);
        wait_idle(70000, "t2_idle");
        chk("t2_w0", wq[0], {25'h0, 8'hC3});
        chk("t2_w1", wq[1], {25'h1, 8'h34});
        chk("t2_w2", wq[2], {25'h2, 8'h12});
        chk("t2_w3", wq[3], {25'h1234, 8'hAA});
        chk("t2_w4", wq[4], {25'h1235, 8'hBB});
        chk("t2_n", wq.size(), 5 + 32'h10000 - 32'h1236);
        bad = 0;
        for (int i = 5; i < wq.size(); i++)
            if (wq[i] !== {25'h1236 + 25'(i - 5), 8'h00}) bad++;
        chk("t2_erase", bad, 0);
        chk("t2_last", wq[wq.size() - 1], {25'hFFFF, 8'h00});

        // Overflow with ready held low.
        wq.delete();
        ram_ready = 1'b0;
        frame2(8'h55, 8'h00);
        frame2(8'h53, 8'h01);
        ss_lo();
        send_byte(8'h54);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        ss_hi();
        frame2(8'h53, 8'h00);
        clks(100);
        chk("t3_ovf", overflow, 1);
        chk("t3_none", wq.size(), 0);
        chk("t3_wr", ram_wr, 1);
        chk("t3_addr", ram_addr, 25'h10000);
        ram_ready = 1'b1;
        wait_idle(40, "t3_idle");
        chk("t3_n", wq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t3_wr", wq[i], {25'h10000 + 25'(i), 8'(i + 1)});
        chk("t3_sticky", overflow, 1);

        // Partial byte discarded by ss.
        wq.delete();
        frame2(8'h53, 8'h01);
        chk("t4_ovf_clr", overflow, 0);
        ss_lo();
        send_byte(8'h54);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        ss_hi();
        chk("t4_none", wq.size(), 0);
        frame2(8'h54, 8'h77);
        frame2(8'h53, 8'h00);
        wait_idle(20, "t4_idle");
        chk("t4_n", wq.size(), 1);
        chk("t4_wr", wq[0], {25'h10000, 8'h77});

        // New start aborts an erase after its pending handshake.
        wq.delete();
        frame2(8'h55, 8'h01);
        frame2(8'h53, 8'h01);
        ss_lo();
        send_byte(8'h54);
        send_byte(8'hFF);
        send_byte(8'h00);
        ss_hi();
        frame2(8'h53, 8'h00);
        k = 0;
        while ((wq.size() < 4 || wq[wq.size() - 1][32:8] < 25'hFF05) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("t5_erasing", k < 500, 1);
        @(posedge clk);
        #1;
        ram_ready = 1'b0;
        n0 = wq.size();
        last = wq[n0 - 1][32:8];
        frame2(8'h55, 8'h00);
        frame2(8'h53, 8'h01);
        clks(5);
        chk("t5_hold_wr", ram_wr, 1);
        chk("t5_hold_a", ram_addr, last + 25'd1);
        chk("t5_hold_d", ram_data, 8'h00);
        ram_ready = 1'b1;
        clks(10);
        chk("t5_one", wq.size(), n0 + 1);
        chk("t5_done", wq[n0], {last + 25'd1, 8'h00});
        chk("t5_stop", ram_wr, 0);
        chk("t5_dl", downloading, 1);
        frame2(8'h54, 8'h5A);
        frame2(8'h53, 8'h00);
        wait_idle(20, "t5_idle");
        chk("t5_n", wq.size(), n0 + 2);
        chk("t5_new", wq[wq.size() - 1], {25'h10000, 8'h5A});

        // Asynchronous reset during a stalled write.
        wq.delete();
        ram_ready = 1'b0;
        frame2(8'h55, 8'h00);
        frame2(8'h53, 8'h01);
        frame2(8'h55, 8'h05);
        frame2(8'h54, 8'hAB);
        clks(5);
        chk("t6_wr", ram_wr, 1);
        chk("t6_addr", ram_addr, 25'h10000);
        chk("t6_idx", index, 5);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_r_wr", ram_wr, 0);
        chk("t6_r_addr", ram_addr, 0);
        chk("t6_r_data", ram_data, 0);
        chk("t6_r_dl", downloading, 0);
        chk("t6_r_idx", index, 0);
        chk("t6_r_ovf", overflow, 0);
        clks(3);
        reset_n = 1'b1;
        ram_ready = 1'b1;
        clks(5);
        chk("t6_empty", ram_wr, 0);
        chk("t6_nowr", wq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
